// File: rtl/battle_pkg.sv
// Shared types, constants and damage helpers for the turn-based battle engine.
package battle_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_PLAYER_SEL,
        ST_PLAYER_ATK,
        ST_ENEMY_WAIT,
        ST_ENEMY_ATK,
        ST_SWITCH,
        ST_DONE,
        ST_EXIT
    } battle_state_t;

    // Move power indexed by move number: {10,15,20,25}
    localparam logic [3:0][7:0] MOVE_POWER = {8'd25, 8'd20, 8'd15, 8'd10};

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Base move power, doubled when the attacker type is one step ahead of the defender
    function automatic logic [7:0] calc_dmg(input logic [2:0] attacker_id,
                                            input logic [2:0] defender_id,
                                            input logic [1:0] move);
        logic [7:0] base;
        base = MOVE_POWER[move];
        if (attacker_id[1:0] == defender_id[1:0] + 2'd1) begin
            return base << 1;
        end
        return base;
    endfunction

    // HP subtraction clamped at zero
    function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
        return (hp <= dmg) ? 8'd0 : hp - dmg;
    endfunction

endpackage

// File: rtl/battle_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every cycle and never reaches zero from a non-zero seed.
module battle_lfsr
    import battle_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic [7:0] value
);

    // Shift right, folding the dropped bit back through the tap mask
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/battle_controller.sv
// Turn-based battle engine driven by the game-state FSM.
// Optional feature: define BATTLE_CRIT_EN to enable critical hits
// (damage doubled again when lfsr[7:5] == 3'b111).
module battle_controller
    import battle_pkg::*;
#(
    parameter logic [7:0]  MAX_HP      = 8'd100,
    parameter logic [23:0] ENEMY_DELAY = 24'd12_500_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            is_battle,
    input  logic [7:0]      keycode,
    input  logic [2:0][2:0] my_team,
    output logic            end_battle,
    output logic            result,
    output logic [1:0]      my_cur,
    output logic [2:0]      enemy_cur_id,
    output logic [7:0]      my_hp,
    output logic [7:0]      enemy_hp,
    output logic [1:0]      move_sel,
    output logic            enemy_turn
);

    battle_state_t state;
    logic [7:0]    prev_key;
    logic [23:0]   counter;
    logic [7:0]    hp [3];
    logic [7:0]    lfsr;
    logic          press;
    logic [2:0]    my_id;
    logic [7:0]    player_dmg;
    logic [7:0]    enemy_dmg;
    logic [7:0]    enemy_hp_next;
    logic [7:0]    my_hp_next;
    logic          unused_lfsr_bits;

    battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .value   (lfsr)
    );

    // Only some LFSR bits feed the game logic in a given build
    assign unused_lfsr_bits = ^lfsr;

    assign press      = (keycode != 8'h00) && (prev_key == 8'h00);
    assign my_hp      = hp[my_cur];
    assign enemy_turn = (state == ST_ENEMY_WAIT) || (state == ST_ENEMY_ATK);

    // Previous keycode for rising-edge key detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_key <= '0;
        end else begin
            prev_key <= keycode;
        end
    end

    // Damage for both attack directions and the resulting HP values
    always_comb begin
        my_id      = my_team[my_cur];
        player_dmg = calc_dmg(my_id, enemy_cur_id, move_sel);
        enemy_dmg  = calc_dmg(enemy_cur_id, my_id, lfsr[1:0]);
`ifdef BATTLE_CRIT_EN
        if (lfsr[7:5] == 3'b111) begin
            player_dmg = player_dmg << 1;
            enemy_dmg  = enemy_dmg << 1;
        end
`endif
        enemy_hp_next = sat_sub(enemy_hp, player_dmg);
        my_hp_next    = sat_sub(hp[my_cur], enemy_dmg);
    end

    // Battle sequencer with registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            end_battle   <= 1'b0;
            result       <= 1'b0;
            my_cur       <= '0;
            enemy_cur_id <= '0;
            enemy_hp     <= '0;
            move_sel     <= '0;
            counter      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                hp[i] <= '0;
            end
        end else begin
            end_battle <= 1'b0;
            if (!is_battle && (state != ST_IDLE) && (state != ST_EXIT)) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (is_battle) begin
                            state <= ST_INIT;
                        end
                    end
                    ST_INIT: begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            hp[i] <= MAX_HP;
                        end
                        enemy_hp     <= MAX_HP;
                        enemy_cur_id <= lfsr[2:0];
                        my_cur       <= '0;
                        move_sel     <= '0;
                        result       <= 1'b0;
                        state        <= ST_PLAYER_SEL;
                    end
                    ST_PLAYER_SEL: begin
                        if (press) begin
                            if (keycode == KEY_W) begin
                                move_sel <= move_sel - 2'd1;
                            end else if (keycode == KEY_S) begin
                                move_sel <= move_sel + 2'd1;
                            end else if (keycode == KEY_ENTER) begin
                                state <= ST_PLAYER_ATK;
                            end
                        end
                    end
                    ST_PLAYER_ATK: begin
                        enemy_hp <= enemy_hp_next;
                        if (enemy_hp_next == 8'd0) begin
                            result <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            counter <= '0;
                            state   <= ST_ENEMY_WAIT;
                        end
                    end
                    ST_ENEMY_WAIT: begin
                        if (counter == ENEMY_DELAY - 24'd1) begin
                            state <= ST_ENEMY_ATK;
                        end else begin
                            counter <= counter + 24'd1;
                        end
                    end
                    ST_ENEMY_ATK: begin
                        hp[my_cur] <= my_hp_next;
                        state      <= (my_hp_next == 8'd0) ? ST_SWITCH : ST_PLAYER_SEL;
                    end
                    ST_SWITCH: begin
                        if (my_cur == 2'd2) begin
                            result <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            my_cur   <= my_cur + 2'd1;
                            move_sel <= '0;
                            state    <= ST_PLAYER_SEL;
                        end
                    end
                    ST_DONE: begin
                        end_battle <= 1'b1;
                        state      <= ST_EXIT;
                    end
                    ST_EXIT: begin
                        if (!is_battle) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_battle_controller.sv
// Self-checking bench for battle_controller (MAX_HP=100, ENEMY_DELAY=4).
module tb_battle_controller;

    localparam logic [7:0] K_W     = 8'h1A;
    localparam logic [7:0] K_S     = 8'h16;
    localparam logic [7:0] K_ENTER = 8'h28;
    localparam logic [7:0] HP0     = 8'd100;
`ifdef BATTLE_CRIT_EN
    localparam bit CRIT_ON = 1'b1;
`else
    localparam bit CRIT_ON = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            is_battle = 1'b0;
    logic [7:0]      keycode = 8'h00;
    logic [2:0][2:0] my_team = '0;
    logic            end_battle;
    logic            result;
    logic [1:0]      my_cur;
    logic [2:0]      enemy_cur_id;
    logic [7:0]      my_hp;
    logic [7:0]      enemy_hp;
    logic [1:0]      move_sel;
    logic            enemy_turn;

    battle_controller #(
        .MAX_HP      (HP0),
        .ENEMY_DELAY (24'd4),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .is_battle    (is_battle),
        .keycode      (keycode),
        .my_team      (my_team),
        .end_battle   (end_battle),
        .result       (result),
        .my_cur       (my_cur),
        .enemy_cur_id (enemy_cur_id),
        .my_hp        (my_hp),
        .enemy_hp     (enemy_hp),
        .move_sel     (move_sel),
        .enemy_turn   (enemy_turn)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference random generator, x^8+x^6+x^5+x^4+1 Galois form
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 8'b1011_1000;
        return n;
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    function automatic logic [7:0] ref_dmg(input logic [2:0] a, input logic [2:0] d,
                                           input logic [1:0] m, input logic [7:0] lf);
        logic [7:0] p;
        logic [1:0] diff;
        p    = 8'd10 + 8'd5 * {6'd0, m};
        diff = a[1:0] - d[1:0];
        if (diff == 2'd1) p = p * 8'd2;
        if (CRIT_ON && lf[7:5] == 3'b111) p = p * 8'd2;
        return p;
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] h, input logic [7:0] d);
        return (h > d) ? h - d : 8'd0;
    endfunction

    logic [7:0] ref_lfsr;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) ref_lfsr <= 8'hA5;
        else          ref_lfsr <= lfsr_step(ref_lfsr);
    end

    // Model state
    logic [2:0] eid;
    logic [7:0] m_hp [3];
    logic [7:0] m_enemy;
    logic [1:0] cur;
    logic [1:0] mv;
    bit         over;
    bit         found;
    logic [7:0] la, lp;
    logic [2:0] tid;
    int         pulses;

    typedef struct {
        logic [7:0] key;
        logic [1:0] exp_move;
    } nav_vec_t;
    nav_vec_t nav [13];

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_end_battle"}, end_battle, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_my_cur"}, my_cur, 0);
        chk({tag, "_enemy_id"}, enemy_cur_id, 0);
        chk({tag, "_my_hp"}, my_hp, 0);
        chk({tag, "_enemy_hp"}, enemy_hp, 0);
        chk({tag, "_move_sel"}, move_sel, 0);
        chk({tag, "_enemy_turn"}, enemy_turn, 0);
    endtask

    task automatic start_battle();
        is_battle = 1'b1;
        tick();
        eid = ref_lfsr[2:0];
        tick();
        chk("init_enemy_hp", enemy_hp, HP0);
        chk("init_my_hp", my_hp, HP0);
        chk("init_my_cur", my_cur, 0);
        chk("init_move_sel", move_sel, 0);
        chk("init_enemy_id", enemy_cur_id, eid);
        chk("init_result", result, 0);
        chk("init_enemy_turn", enemy_turn, 0);
        for (int i = 0; i < 3; i++) m_hp[i] = HP0;
        m_enemy = HP0;
        cur = 2'd0;
        mv = 2'd0;
    endtask

    // One ENTER-initiated round; ends in PLAYER_SEL, or after the end_battle pulse
    task automatic player_turn(output bit fin);
        logic [7:0] d;
        logic [7:0] lf;
        logic [2:0] mine;
        fin = 1'b0;
        mine = my_team[cur];
        keycode = K_ENTER;
        tick();
        keycode = 8'h00;
        chk("atk_enemy_turn", enemy_turn, 0);
        lf = ref_lfsr;
        d = ref_dmg(mine, eid, mv, lf);
        m_enemy = sat(m_enemy, d);
        tick();
        chk("enemy_hp", enemy_hp, m_enemy);
        if (m_enemy == 8'd0) begin
            chk("win_pulse_early", end_battle, 0);
            tick();
            chk("win_pulse", end_battle, 1);
            chk("win_result", result, 1);
            tick();
            chk("win_pulse_end", end_battle, 0);
            fin = 1'b1;
            return;
        end
        for (int i = 2; i <= 6; i++) begin
            if (i > 2) tick();
            chk("wait_enemy_turn", enemy_turn, 1);
            chk("wait_no_pulse", end_battle, 0);
            if (i == 6) lf = ref_lfsr;
        end
        d = ref_dmg(eid, mine, lf[1:0], lf);
        m_hp[cur] = sat(m_hp[cur], d);
        tick();
        chk("enemy_turn_off", enemy_turn, 0);
        chk("my_hp", my_hp, m_hp[cur]);
        if (m_hp[cur] == 8'd0) begin
            tick();
            if (cur == 2'd2) begin
                chk("loss_pulse_early", end_battle, 0);
                tick();
                chk("loss_pulse", end_battle, 1);
                chk("loss_result", result, 0);
                chk("loss_my_cur", my_cur, 2);
                tick();
                chk("loss_pulse_end", end_battle, 0);
                fin = 1'b1;
            end else begin
                cur = cur + 2'd1;
                mv = 2'd0;
                chk("switch_my_cur", my_cur, cur);
                chk("switch_my_hp", my_hp, HP0);
                chk("switch_move_sel", move_sel, 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        nav[0]  = '{8'h00, 2'd1};
        nav[1]  = '{K_W,   2'd0};
        nav[2]  = '{8'h00, 2'd0};
        nav[3]  = '{K_W,   2'd3};
        nav[4]  = '{K_W,   2'd3};
        nav[5]  = '{K_S,   2'd3};
        nav[6]  = '{8'h00, 2'd3};
        nav[7]  = '{8'h04, 2'd3};
        nav[8]  = '{8'h00, 2'd3};
        nav[9]  = '{K_S,   2'd0};
        nav[10] = '{8'h00, 2'd0};
        nav[11] = '{K_W,   2'd3};
        nav[12] = '{8'h00, 2'd3};

        // Power-on reset
        repeat (2) tick();
        chk_all_zero("por");
        Reset_n = 1'b1;
        tick();
        chk("idle_quiet", enemy_hp, 0);

        // Battle 1: navigation, one full round, then abort
        my_team = {3'd2, 3'd1, 3'd0};
        start_battle();
        keycode = K_S;
        repeat (50) tick();
        chk("hold_s", move_sel, 1);
        for (int i = 0; i < 13; i++) begin
            keycode = nav[i].key;
            tick();
            chk($sformatf("nav%0d_move", i), move_sel, nav[i].exp_move);
            chk($sformatf("nav%0d_turn", i), enemy_turn, 0);
        end
        mv = 2'd3;
        player_turn(over);
        if (!over) begin
            keycode = K_S;
            tick();
            keycode = 8'h00;
            chk("wrap_s", move_sel, 0);
            tick();
            keycode = K_ENTER;
            tick();
            keycode = 8'h00;
            tick();
            chk("abort_in_wait", enemy_turn, 1);
            tick();
            is_battle = 1'b0;
            tick();
            chk("abort_idle", enemy_turn, 0);
            pulses = 0;
            repeat (8) begin
                if (end_battle) pulses++;
                tick();
            end
            chk("abort_no_pulse", pulses, 0);
            chk("abort_my_hp_held", my_hp, m_hp[cur]);
            chk("abort_result_held", result, 0);
        end else begin
            is_battle = 1'b0;
            repeat (2) tick();
        end

        // Battle 2: fresh INIT, then reset while in PLAYER_SEL
        start_battle();
        keycode = K_S;
        tick();
        keycode = 8'h00;
        chk("pre_reset_move", move_sel, 1);
        Reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        is_battle = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_rst_pulse", end_battle, 0);
        chk("post_rst_enemy_hp", enemy_hp, 0);

        // Battle 3: enemy always has the type bonus and the heaviest move -> loss
        start_battle();
        tid = {1'b0, eid[1:0] - 2'd1};
        my_team = {tid, tid, tid};
        over = 1'b0;
        for (int t = 0; t < 10 && !over; t++) begin
            found = 1'b0;
            for (int k = 0; k < 300 && !found; k++) begin
                la = lfsr_adv(ref_lfsr, 6);
                lp = lfsr_adv(ref_lfsr, 1);
                if (la[1:0] == 2'b11 && lp[7:5] != 3'b111) found = 1'b1;
                else tick();
            end
            chk("loss_slot_found", found, 1);
            player_turn(over);
        end
        chk("loss_reached", over, 1);
        repeat (4) begin
            tick();
            chk("exit_hold_pulse", end_battle, 0);
        end
        chk("exit_hold_result", result, 0);
        chk("exit_hold_cur", my_cur, 2);
        chk("exit_hold_enemy_hp", enemy_hp, m_enemy);
        is_battle = 1'b0;
        tick();

        // Battle 4: player has the type bonus and move 3 -> win
        start_battle();
        tid = {1'b0, eid[1:0] + 2'd1};
        my_team = {tid, tid, tid};
        keycode = K_W;
        tick();
        keycode = 8'h00;
        chk("win_nav_w", move_sel, 3);
        mv = 2'd3;
        tick();
        over = 1'b0;
        for (int n = 0; n < 6 && !over; n++) player_turn(over);
        chk("win_reached", over, 1);
        repeat (3) tick();
        chk("win_hold_result", result, 1);
        chk("win_hold_enemy_hp", enemy_hp, 0);
        is_battle = 1'b0;
        repeat (2) tick();
        chk("idle_result_held", result, 1);
        chk("idle_no_pulse", end_battle, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
